// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 keyboard receiver that keeps a one-hot "held letter" bus.
// Ports: CLOCK_50/reset (async, high); PS2_CLK/PS2_DAT raw keyboard pins;
//   letter (bit0=A..bit25=Z, 0=none), letter_valid (new non-zero letter),
//   frame_err (parity, start, stop or inter-edge timeout error pulse).
module ps2_letter_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [25:0] letter,
  output logic        letter_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------
  // Pin synchronisers (reset to the idle-high line level)
  // ---------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_s;
  logic       dat_s;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // ---------------------------------------------------------------
  // Clock glitch filter: level moves only once the whole history
  // window agrees, so short spikes never reach the frame FSM.
  // ---------------------------------------------------------------
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  filt_d;
  logic                  all_hi;
  logic                  all_lo;
  logic                  fall;

  assign all_hi = &hist_q;
  assign all_lo = ~|hist_q;

  always_comb begin
    filt_d = filt_q;
    if (all_hi) begin
      filt_d = 1'b1;
    end else if (all_lo) begin
      filt_d = 1'b0;
    end
  end

  assign fall = filt_q & all_lo;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[FILTER_LEN-2:0], clk_s};
      filt_q <= filt_d;
    end
  end

  // ---------------------------------------------------------------
  // Letter lookup: set-2 make code -> one-hot position
  // ---------------------------------------------------------------
  function automatic logic [25:0] letter_onehot(input logic [7:0] code);
    logic [4:0] idx;
    logic       hit;
    idx = '0;
    hit = 1'b1;
    case (code)
      8'h1C: idx = 5'd0;
      8'h32: idx = 5'd1;
      8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;
      8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;
      8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;
      8'h42: idx = 5'd10;
      8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;
      8'h31: idx = 5'd13;
      8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;
      8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;
      8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;
      8'h1D: idx = 5'd22;
      8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;
      8'h1A: idx = 5'd25;
      default: hit = 1'b0;
    endcase
    return hit ? (26'd1 << idx) : 26'd0;
  endfunction

  // ---------------------------------------------------------------
  // Frame FSM state
  // ---------------------------------------------------------------
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_d;
  logic          deliver;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    deliver  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (fall) begin
          if (!dat_s) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (dat_s && (^{shift_q, par_q})) begin
            deliver = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-edge watchdog: a keyboard that stops clocking mid-frame
    // must not leave the receiver stuck half-way through a byte.
    if (state_q != S_IDLE) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_MAX) begin
        state_d  = S_IDLE;
        err_d    = 1'b1;
        shift_d  = '0;
        bitcnt_d = '0;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
    end
  end

  // ---------------------------------------------------------------
  // Byte layer: prefix tracking and held-letter update
  // ---------------------------------------------------------------
  logic [25:0] letter_q, letter_d;
  logic        valid_q, valid_d;
  logic        err_q;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic [25:0] code_oh;

  assign code_oh = letter_onehot(shift_q);

  always_comb begin
    letter_d = letter_q;
    valid_d  = 1'b0;
    brk_d    = brk_q;
    ext_d    = ext_q;

    if (err_d) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (deliver) begin
      if (shift_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys share codes with letters; drop them.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (|code_oh) begin
        if (!brk_q) begin
          // Typematic repeats of the held key stay silent.
          if (code_oh != letter_q) begin
            letter_d = code_oh;
            valid_d  = 1'b1;
          end
        end else if (code_oh == letter_q) begin
          letter_d = '0;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      letter_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Scoreboard bench for ps2_letter_decoder: frames are bit-banged on the
// PS/2 pins, expected letter_valid values queued and matched in order.
module tb_ps2_letter_decoder;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2c;
  logic        ps2d;
  logic [25:0] letter;
  logic        letter_valid;
  logic        frame_err;

  always #10 clk = ~clk;

  ps2_letter_decoder #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .PS2_CLK     (ps2c),
    .PS2_DAT     (ps2d),
    .letter      (letter),
    .letter_valid(letter_valid),
    .frame_err   (frame_err)
  );

  // Observed outputs, recorded away from the active edge
  logic [25:0] obs_q[$];
  int          err_seen = 0;

  always @(negedge clk) begin
    if (letter_valid) obs_q.push_back(letter);
    if (frame_err) err_seen++;
  end

  logic [25:0] exp_q[$];
  logic [25:0] e;
  logic [25:0] g;
  int          rd;
  int          eb;
  int          n_run  = 0;
  int          n_fail = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2d = b;
    if (glitch) begin
      cyc(5);
      ps2c = 1'b0;
      cyc(1);
      ps2c = 1'b1;
      cyc(HALF - 6);
    end else begin
      cyc(HALF);
    end
    ps2c = 1'b0;
    cyc(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit glitch, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch);
    ps2d = 1'b1;
    cyc(3 * HALF);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    rd = obs_q.size();
    exp_q.delete();
    eb = err_seen;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (letter !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_letter got %h want 0", letter);
    end
    n_run++;
    if (letter_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", letter_valid);
    end
    n_run++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b want 0", frame_err);
    end
  endtask

  task automatic test_single_make();
    do_reset();
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL single_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL single_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 0) begin
      n_fail++;
      $display("FAIL single_err got %0d want 0", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h1) begin
      n_fail++;
      $display("FAIL single_letter got %h want 1", letter);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    n_run++;
    if (letter !== 26'h1) begin
      n_fail++;
      $display("FAIL typematic_held got %h want 1", letter);
    end
    send_frame(8'h1C, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL typematic_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL typematic_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 0) begin
      n_fail++;
      $display("FAIL typematic_err got %0d want 0", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h0) begin
      n_fail++;
      $display("FAIL typematic_release got %h want 0", letter);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    exp_q.push_back(26'h2000000);
    send_frame(8'h1A, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rollover_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL rollover_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (letter !== 26'h2000000) begin
      n_fail++;
      $display("FAIL rollover_letter got %h want 2000000", letter);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h1C, 1, 0, 11);
    n_run++;
    if (letter !== 26'h0) begin
      n_fail++;
      $display("FAIL parity_letter got %h want 0", letter);
    end
    exp_q.push_back(26'h2);
    send_frame(8'h32, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL parity_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL parity_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 1) begin
      n_fail++;
      $display("FAIL parity_err got %0d want 1", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h2) begin
      n_fail++;
      $display("FAIL parity_next got %h want 2", letter);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(8'h1C, 0, 0, 4);
    cyc(TMO + 50);
    n_run++;
    if (err_seen - eb != 1) begin
      n_fail++;
      $display("FAIL timeout_err got %0d want 1", err_seen - eb);
    end
    exp_q.push_back(26'h4000);
    send_frame(8'h44, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL timeout_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL timeout_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 1) begin
      n_fail++;
      $display("FAIL timeout_err_total got %0d want 1", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h4000) begin
      n_fail++;
      $display("FAIL timeout_letter got %h want 4000", letter);
    end
  endtask

  task automatic test_ext_glitch();
    do_reset();
    send_frame(8'hE0, 0, 1, 11);
    send_frame(8'h1C, 0, 1, 11);
    send_frame(8'hF0, 0, 1, 11);
    send_frame(8'h3C, 0, 1, 11);
    n_run++;
    if (letter !== 26'h0) begin
      n_fail++;
      $display("FAIL ext_letter got %h want 0", letter);
    end
    exp_q.push_back(26'h100000);
    send_frame(8'h3C, 0, 1, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL ext_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL ext_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 0) begin
      n_fail++;
      $display("FAIL ext_err got %0d want 0", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h100000) begin
      n_fail++;
      $display("FAIL ext_u_letter got %h want 100000", letter);
    end
  endtask

  task automatic test_bad_start();
    do_reset();
    send_bit(1'b1, 0);
    cyc(3 * HALF);
    n_run++;
    if (err_seen - eb != 1) begin
      n_fail++;
      $display("FAIL badstart_err got %0d want 1", err_seen - eb);
    end
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL badstart_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL badstart_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (letter !== 26'h1) begin
      n_fail++;
      $display("FAIL badstart_letter got %h want 1", letter);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    send_frame(8'h1A, 0, 0, 6);
    rst  = 1'b1;
    ps2d = 1'b1;
    cyc(2);
    n_run++;
    if (letter !== 26'h0) begin
      n_fail++;
      $display("FAIL abort_letter got %h want 0", letter);
    end
    rst = 1'b0;
    cyc(10);
    exp_q.push_back(26'h2);
    send_frame(8'h32, 0, 0, 11);
    exp_q.push_back(26'h1);
    send_frame(8'h1C, 0, 0, 11);
    cyc(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < obs_q.size()) ? obs_q[rd] : 'x;
      rd++;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_pulse got %h want %h", g, e);
      end
    end
    n_run++;
    if (rd != obs_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), rd);
    end
    rd = obs_q.size();
    n_run++;
    if (err_seen - eb != 0) begin
      n_fail++;
      $display("FAIL b2b_err got %0d want 0", err_seen - eb);
    end
    n_run++;
    if (letter !== 26'h1) begin
      n_fail++;
      $display("FAIL b2b_letter got %h want 1", letter);
    end
  endtask

  initial begin
    rst  = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    rd   = 0;
    eb   = 0;
    test_reset();
    test_single_make();
    test_typematic();
    test_rollover();
    test_parity();
    test_timeout();
    test_ext_glitch();
    test_bad_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
